// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
// The master issues operands and start; the slave returns status and the difference.
interface bcd_serial_subtractor_if #(
    parameter int unsigned DIGITS = 4
) ();

    logic                  start;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  Bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   D;
    logic                  Bout;
    logic                  invalid;

    modport master (
        output start,
        output A,
        output B,
        output Bin,
        input  busy,
        input  done,
        input  D,
        input  Bout,
        input  invalid
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        input  Bin,
        output busy,
        output done,
        output D,
        output Bout,
        output invalid
    );

endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor D = A - B - Bin, one digit per clock, LSD first,
// with the inter-digit borrow carried in a register between cycles.
module bcd_serial_subtractor #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_serial_subtractor_if.slave bus
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    d_q, d_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic            bout_q, bout_d;
    logic            invalid_q, invalid_d;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      d_dig;
    logic [4:0]      diff;
    logic            dig_borrow;
    logic            bad_operand;

    function automatic logic has_bad_nibble(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign bad_operand = has_bad_nibble(bus.A) || has_bad_nibble(bus.B);

    // Single-digit datapath; diff[4] is the sign of a - b - borrow (range -10..9).
    always_comb begin
        a_dig      = a_q[4*idx_q +: 4];
        b_dig      = b_q[4*idx_q +: 4];
        diff       = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow_q};
        dig_borrow = diff[4];
        d_dig      = dig_borrow ? (diff[3:0] + 4'd10) : diff[3:0];
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        invalid_d = invalid_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d       = bus.A;
                    b_d       = bus.B;
                    invalid_d = 1'b0;
                    if (bad_operand) begin
                        invalid_d = 1'b1;
                        d_d       = '0;
                        bout_d    = 1'b0;
                        state_d   = StDone;
                    end else begin
                        borrow_d = bus.Bin;
                        idx_d    = '0;
                        state_d  = StRun;
                    end
                end
            end
            StRun: begin
                // Unprocessed digits keep whatever the previous result left there.
                d_d[4*idx_q +: 4] = d_dig;
                borrow_d          = dig_borrow;
                if (idx_q == LastIdx) begin
                    bout_d  = dig_borrow;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            idx_q     <= '0;
            borrow_q  <= 1'b0;
            bout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_q       <= d_d;
            idx_q     <= idx_d;
            borrow_q  <= borrow_d;
            bout_q    <= bout_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.busy    = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.D       = d_q;
    assign bus.Bout    = bout_q;
    assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4) with hand-computed expectations.
module tb_bcd_serial_subtractor;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy length and the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] exp_d, input logic exp_bout);
        int n;
        int busy_n;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n         = 0;
        busy_n    = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) busy_n++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_busy_cycles"}, busy_n, 4);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
        chk({tag, "_D"}, bus.D, exp_d);
        chk({tag, "_Bout"}, bus.Bout, exp_bout);
        chk({tag, "_invalid"}, bus.invalid, 0);
        tick();
        chk({tag, "_done_pulse_width"}, bus.done, 0);
    endtask

    task automatic run_invalid(input string tag, input logic [15:0] a, input logic [15:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_invalid"}, bus.invalid, 1);
        chk({tag, "_D"}, bus.D, 16'h0000);
        chk({tag, "_Bout"}, bus.Bout, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        tick();
        chk({tag, "_done_after"}, bus.done, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        int         ndone;
        int         n;
        int         cyc;
        int         t_first;
        logic [15:0] cap_d;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;

        #12;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_D", bus.D, 16'h0000);
        chk("reset_Bout", bus.Bout, 0);
        chk("reset_invalid", bus.invalid, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic subtraction with a borrow rippling through three digits.
        run_op("t1", 16'h9000, 16'h1234, 1'b0, 16'h7766, 1'b0);

        // Wrap-around and borrow-in cases.
        run_op("t2a", 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1);
        run_op("t2b", 16'h5000, 16'h5000, 1'b1, 16'h9999, 1'b1);
        run_op("t2c", 16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0);

        // Extra start and operand change during RUN are ignored.
        bus.A     = 16'h4321;
        bus.B     = 16'h1111;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.A     = 16'h0000;
        tick();
        bus.start = 1'b0;
        ndone     = 0;
        cap_d     = 16'hxxxx;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                ndone++;
                cap_d = bus.D;
            end
            tick();
        end
        chk("t4_done_count", ndone, 1);
        chk("t4_D", cap_d, 16'h3210);

        // Invalid nibble in A, then in B only.
        run_invalid("t3a", 16'h00A0, 16'h0000);
        bus.A = 16'h4321;
        bus.B = 16'h1111;
        run_op("t3_mid", 16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0);
        run_invalid("t3b", 16'h0000, 16'hF000);

        // Reset mid-operation, after digits 0 and 1 have been written.
        bus.A     = 16'h9000;
        bus.B     = 16'h1234;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("t5_pre_D", bus.D, 16'h0066);
        rst = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_D", bus.D, 16'h0000);
        chk("t5_Bout", bus.Bout, 0);
        chk("t5_done", bus.done, 0);
        tick();
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("t5_no_done", ndone, 0);
        run_op("t5_after", 16'h0010, 16'h0009, 1'b0, 16'h0001, 1'b0);

        // start held high: back-to-back operations, done pulses 6 cycles apart.
        bus.A     = 16'h1000;
        bus.B     = 16'h0001;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        cyc   = 0;
        bus.A = 16'h0500;
        bus.B = 16'h0600;
        n     = 0;
        while (!bus.done && n < 20) begin
            tick();
            cyc++;
            n++;
        end
        chk("t6a_done", bus.done, 1);
        chk("t6a_D", bus.D, 16'h0999);
        chk("t6a_Bout", bus.Bout, 0);
        t_first = cyc;
        tick();
        cyc++;
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            cyc++;
            n++;
        end
        bus.start = 1'b0;
        chk("t6b_done", bus.done, 1);
        chk("t6b_spacing", cyc - t_first, 6);
        chk("t6b_D", bus.D, 16'h9900);
        chk("t6b_Bout", bus.Bout, 1);
        tick();
        tick();
        chk("t6_idle_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
